inst_axi_rd_bridge: RTL and testbench
=====================================

// Module: inst_axi_rd_bridge
// PURPOSE
//  Converts the fetch stage's SRAM-like instruction port (req/addr_ok/data_ok) into AXI4 read channels (AR/R).
//  Sits directly upstream of IF and feeds it instruction words.
//  Read-only; requests are in-order, single-beat and share one fixed ARID.
//  Holds AR stable until arready; bounds outstanding reads so every R beat can be accepted.
// PARAMETERS
//  MAX_OUTST  4     max accepted-but-unreturned reads (1..255)
//  AXI_ID     4'd0  constant ARID for all reads
// PORTS
//  clk              in   1   clock, rising edge
//  resetn           in   1   asynchronous active-low reset
//  inst_sram_req    in   1   fetch request valid
//  inst_sram_wr     in   1   write flag; must be 0 (writes never accepted)
//  inst_sram_size   in   2   log2 bytes; 2'b10 for fetch
//  inst_sram_addr   in   32  fetch address
//  inst_sram_wstrb  in   4   unused
//  inst_sram_wdata  in   32  unused
//  inst_sram_addr_ok out 1   request accepted this cycle
//  inst_sram_data_ok out 1   rdata valid this cycle (1-cycle pulse)
//  inst_sram_rdata  out  32  instruction word
//  arid/araddr/arlen/arsize out 4/32/8/3  AXI AR payload
//  arburst/arlock/arcache/arprot out 2/2/4/3  fixed 2'b01/0/0/0
//  arvalid  out 1  |  arready  in 1
//  rid in 4 | rdata in 32 | rresp in 2 | rlast in 1 | rvalid in 1 | rready out 1
//  wr_req_err       out  1   sticky: set if req&wr ever seen; cleared by reset only
// BEHAVIOUR
//  Reset (resetn=0, async): arvalid=0, araddr=0, arsize=0, cnt=0, addr_ok=0, data_ok=0, rready=1
//    (0 with RBUF empty is not allowed), wr_req_err=0. The AXI slave shares resetn; no pending beats survive reset.
//  AR slot: ar_free = ~arvalid | arready.
//  addr_ok = req & ~wr & ar_free & (cnt < MAX_OUTST | r_fire_last); combinational, same cycle as req.
//  On addr_ok: araddr<=addr, arsize<={1'b0,size}, arvalid<=1 next cycle; else if arready: arvalid<=0.
//    Back-to-back: an AR handshake and a new accept in the same cycle reload the slot, arvalid stays 1.
//  arvalid/araddr/arsize never change while arvalid&~arready (AXI stability).
//  arlen=0, arid=AXI_ID always.
//  cnt (8b): +1 on addr_ok, -1 on data_ok; both same cycle -> unchanged. Never exceeds MAX_OUTST; no underflow.
//  R path (no RBUF): rready=1; data_ok=rvalid&rlast; rdata passed through; latency AR->data_ok = slave latency.
//  rresp/rid ignored for data; responses return in issue order.
//  Drop of req by IF after addr_ok is harmless; IF discards stale data_ok by its own count.
//  req & wr: addr_ok=0 forever for that request; wr_req_err<=1.
//  cnt==MAX_OUTST and no returning beat: addr_ok=0 until a data_ok.
// CONFIGURATION
//  INST_AXI_RBUF_EN defined: 1-entry R buffer.
//    rready=~buf_v | data_ok; beat captured on rvalid&rready; data_ok=buf_v, rdata=buf_q.
//    One extra cycle of latency; buf_v cleared on reset. Full-throughput: a new capture occurs in the same cycle as
//    data_ok.
//  Undefined: combinational pass-through as above; no buf registers exist.
// TESTING
//  1 Reset: hold resetn=0 mid-transfer (arvalid=1, cnt=2) -> arvalid=0, cnt=0, data_ok=0 asynchronously.
//  2 Single fetch: req, addr=0x1c000000, arready=1, R 3 cycles later with rdata=0x02800c0c
//    -> addr_ok at cycle 0, arvalid cycle 1, data_ok+rdata at R cycle (+1 with RBUF).
//  3 AR backpressure: arready=0 for 5 cycles while req stays high, addr=0x1c000004
//    -> araddr stable, addr_ok=0 cycles 1-5, second accept in the arready cycle.
//  4 Credit limit: arready=1, rvalid=0, 6 back-to-back reqs -> exactly 4 addr_ok; 5th accepted the cycle rvalid&rlast
//    returns.
//  5 Write request: req=1, wr=1 -> addr_ok stays 0, arvalid stays 0, wr_req_err=1 until reset.
//  6 Order: 3 reads 0x0/0x4/0x8, slave returns 0xA,0xB,0xC -> data_ok x3 in same order, cnt back to 0.

Source files
------------

// File: rtl/inst_axi_rd_bridge.sv
// Bridges the fetch stage's SRAM-like instruction port onto AXI4 AR/R read channels.
// Optional 1-entry R buffer enabled by defining INST_AXI_RBUF_EN.
module inst_axi_rd_bridge #(
    parameter int unsigned MAX_OUTST = 4,
    parameter logic [3:0]  AXI_ID    = 4'd0
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic        wr_req_err
);

    localparam logic [7:0] MaxOutst = 8'(MAX_OUTST);

    logic        arvalid_q, arvalid_d;
    logic [31:0] araddr_q,  araddr_d;
    logic [2:0]  arsize_q,  arsize_d;
    logic [7:0]  cnt_q,     cnt_d;
    logic        err_q,     err_d;

    logic        ar_free;
    logic        accept;
    logic        data_ok_w;
    logic        cnt_dec;

    // Write-side and response-id/resp inputs carry nothing this read-only bridge needs.
    logic        unused_inputs;
    assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rid, rresp};

`ifdef INST_AXI_RBUF_EN
    logic        buf_v_q, buf_v_d;
    logic [31:0] buf_q,   buf_d;
    logic        r_capture;

    // IF always consumes data_ok, so the buffer can refill in the cycle it drains.
    assign data_ok_w       = resetn & buf_v_q;
    assign rready          = ~buf_v_q | data_ok_w;
    assign r_capture       = rvalid & rready & rlast;
    assign inst_sram_rdata = buf_q;

    always_comb begin
        buf_v_d = buf_v_q;
        buf_d   = buf_q;
        if (r_capture) begin
            buf_v_d = 1'b1;
            buf_d   = rdata;
        end else if (data_ok_w) begin
            buf_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_v_q <= 1'b0;
            buf_q   <= '0;
        end else begin
            buf_v_q <= buf_v_d;
            buf_q   <= buf_d;
        end
    end
`else
    assign rready          = 1'b1;
    assign data_ok_w       = resetn & rvalid & rlast;
    assign inst_sram_rdata = rdata;
`endif

    // A returning beat frees its credit in the same cycle, so a full window can still accept.
    always_comb begin
        ar_free = ~arvalid_q | arready;
        accept  = resetn & inst_sram_req & ~inst_sram_wr & ar_free
                  & ((cnt_q < MaxOutst) | data_ok_w);
        cnt_dec = data_ok_w & (cnt_q != 8'd0);
    end

    always_comb begin
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arsize_d  = arsize_q;
        cnt_d     = cnt_q + 8'(accept) - 8'(cnt_dec);
        err_d     = err_q | (inst_sram_req & inst_sram_wr);
        if (accept) begin
            arvalid_d = 1'b1;
            araddr_d  = inst_sram_addr;
            arsize_d  = {1'b0, inst_sram_size};
        end else if (arready) begin
            arvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arsize_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arsize_q  <= arsize_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign inst_sram_addr_ok = accept;
    assign inst_sram_data_ok = data_ok_w;

    assign arid    = AXI_ID;
    assign araddr  = araddr_q;
    assign arlen   = 8'd0;
    assign arsize  = arsize_q;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = arvalid_q;

    assign wr_req_err = err_q;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Self-checking bench for inst_axi_rd_bridge: directed scenarios plus randomized traffic
// against a queue-based in-order read model.
module tb_inst_axi_rd_bridge;

`ifdef INST_AXI_RBUF_EN
    localparam int RLAT = 1;
`else
    localparam int RLAT = 0;
`endif
    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic        wr_req_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inst_axi_rd_bridge #(.MAX_OUTST(MAXO), .AXI_ID(4'd0)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .wr_req_err(wr_req_err)
    );

    function automatic logic [31:0] fdat(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic set_idle();
        inst_sram_req   = 1'b0;
        inst_sram_wr    = 1'b0;
        inst_sram_size  = 2'b10;
        inst_sram_addr  = '0;
        inst_sram_wstrb = '0;
        inst_sram_wdata = '0;
        arready         = 1'b1;
        rvalid          = 1'b0;
        rlast           = 1'b0;
        rdata           = '0;
        rid             = 4'd0;
        rresp           = 2'b00;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    // Slave returns n beats back to back, then lets any buffered beat drain.
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            rvalid = 1'b1; rlast = 1'b1; rdata = $urandom;
            next_cycle();
        end
        rvalid = 1'b0; rlast = 1'b0;
        repeat (RLAT + 1) next_cycle();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({arvalid, araddr, arsize, rready, wr_req_err, inst_sram_addr_ok, inst_sram_data_ok}
            !== {1'b0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got arv=%b addr=%h size=%b rready=%b err=%b aok=%b dok=%b",
                     arvalid, araddr, arsize, rready, wr_req_err, inst_sram_addr_ok, inst_sram_data_ok);
        end
        @(posedge clk); #1;
        inst_sram_req = 1'b1; inst_sram_addr = 32'h100; arready = 1'b1;
        repeat (2) next_cycle();
        arready = 1'b0;
        #1;
        checks++;
        if (arvalid !== 1'b1) begin
            errors++; $display("FAIL reset_pre_arvalid got %b exp 1", arvalid);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({arvalid, araddr, inst_sram_addr_ok, inst_sram_data_ok} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_async got arv=%b addr=%h aok=%b dok=%b exp 0/0/0/0",
                     arvalid, araddr, inst_sram_addr_ok, inst_sram_data_ok);
        end
        set_idle();
        @(posedge clk); #1 resetn = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_fetch();
        for (int c = 0; c < 6; c++) begin
            set_idle();
            if (c == 0) begin
                inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0000;
            end
            if (c == 3) begin
                rvalid = 1'b1; rlast = 1'b1; rdata = 32'h0280_0c0c;
            end
            @(negedge clk);
            checks++;
            if ({inst_sram_addr_ok, arvalid, inst_sram_data_ok} !== {c == 0, c == 1, c == 3 + RLAT}) begin
                errors++;
                $display("FAIL single_hs c%0d got aok/arv/dok=%b%b%b exp %b%b%b", c,
                         inst_sram_addr_ok, arvalid, inst_sram_data_ok, c == 0, c == 1, c == 3 + RLAT);
            end
            if (c == 1) begin
                checks++;
                if ({araddr, arsize, arlen, arid, arburst, arlock, arcache, arprot}
                    !== {32'h1c00_0000, 3'b010, 8'd0, 4'd0, 2'b01, 2'b00, 4'd0, 3'd0}) begin
                    errors++;
                    $display("FAIL single_ar got addr=%h size=%b len=%h id=%h burst=%b", araddr, arsize,
                             arlen, arid, arburst);
                end
            end
            if (c == 3 + RLAT) begin
                checks++;
                if (inst_sram_rdata !== 32'h0280_0c0c) begin
                    errors++; $display("FAIL single_rdata got %h exp 02800c0c", inst_sram_rdata);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_ar_backpressure();
        for (int c = 0; c < 9; c++) begin
            set_idle();
            inst_sram_req  = (c <= 6);
            inst_sram_addr = (c == 0) ? 32'h1c00_0004 : 32'h1c00_0008;
            arready        = !(c >= 1 && c <= 5) && c != 0;
            @(negedge clk);
            checks++;
            if ({inst_sram_addr_ok, arvalid} !== {c == 0 || c == 6, c >= 1 && c <= 7}) begin
                errors++;
                $display("FAIL bp_hs c%0d got aok/arv=%b%b exp %b%b", c, inst_sram_addr_ok, arvalid,
                         c == 0 || c == 6, c >= 1 && c <= 7);
            end
            if (c >= 1 && c <= 7) begin
                checks++;
                if (araddr !== ((c == 7) ? 32'h1c00_0008 : 32'h1c00_0004)) begin
                    errors++; $display("FAIL bp_araddr c%0d got %h", c, araddr);
                end
            end
            next_cycle();
        end
        set_idle();
        drain(2);
    endtask

    task automatic test_credit_limit();
        int n_ok = 0;
        set_idle();
        inst_sram_req = 1'b1;
        for (int c = 0; c < 6; c++) begin
            inst_sram_addr = 32'h2000 + 32'(4 * c);
            @(negedge clk);
            if (inst_sram_addr_ok === 1'b1) n_ok++;
            next_cycle();
        end
        checks++;
        if (n_ok != MAXO) begin
            errors++; $display("FAIL credit_count got %0d accepts exp %0d", n_ok, MAXO);
        end
        rvalid = 1'b1; rlast = 1'b1; rdata = 32'h55;
        @(negedge clk);
        checks++;
        if (inst_sram_addr_ok !== (RLAT == 0)) begin
            errors++; $display("FAIL credit_return got aok=%b exp %b", inst_sram_addr_ok, RLAT == 0);
        end
        next_cycle();
        rvalid = 1'b0; rlast = 1'b0;
        if (RLAT != 0) begin
            @(negedge clk);
            checks++;
            if (inst_sram_addr_ok !== 1'b1) begin
                errors++; $display("FAIL credit_return_buf got aok=%b exp 1", inst_sram_addr_ok);
            end
            next_cycle();
        end
        set_idle();
        drain(MAXO);
    endtask

    task automatic test_write_req();
        for (int c = 0; c < 5; c++) begin
            set_idle();
            inst_sram_req = (c < 3); inst_sram_wr = (c < 3); inst_sram_addr = 32'h3000;
            @(negedge clk);
            checks++;
            if ({inst_sram_addr_ok, arvalid, wr_req_err} !== {1'b0, 1'b0, c != 0}) begin
                errors++;
                $display("FAIL write_req c%0d got aok/arv/err=%b%b%b exp 00%b", c, inst_sram_addr_ok,
                         arvalid, wr_req_err, c != 0);
            end
            next_cycle();
        end
        do_reset();
        #1;
        checks++;
        if (wr_req_err !== 1'b0) begin
            errors++; $display("FAIL write_err_clear got %b exp 0", wr_req_err);
        end
    endtask

    task automatic test_order();
        int n_ok = 0;
        logic [31:0] exp_d;
        for (int c = 0; c < 9; c++) begin
            set_idle();
            inst_sram_req  = (c < 3);
            inst_sram_addr = 32'(4 * c);
            if (c >= 4 && c <= 6) begin
                rvalid = 1'b1; rlast = 1'b1; rdata = 32'hA + 32'(c - 4);
            end
            @(negedge clk);
            checks++;
            if ({inst_sram_addr_ok, inst_sram_data_ok} !== {c < 3, c >= 4 + RLAT && c <= 6 + RLAT}) begin
                errors++;
                $display("FAIL order_hs c%0d got aok/dok=%b%b", c, inst_sram_addr_ok, inst_sram_data_ok);
            end
            if (c >= 4 + RLAT && c <= 6 + RLAT) begin
                exp_d = 32'hA + 32'(c - 4 - RLAT);
                checks++;
                if (inst_sram_rdata !== exp_d) begin
                    errors++; $display("FAIL order_rdata c%0d got %h exp %h", c, inst_sram_rdata, exp_d);
                end
            end
            next_cycle();
        end
        set_idle();
        inst_sram_req = 1'b1;
        for (int c = 0; c < MAXO + 1; c++) begin
            @(negedge clk);
            if (inst_sram_addr_ok === 1'b1) n_ok++;
            next_cycle();
        end
        checks++;
        if (n_ok != MAXO) begin
            errors++; $display("FAIL order_cnt_zero got %0d accepts exp %0d", n_ok, MAXO);
        end
        set_idle();
        drain(MAXO);
    endtask

    // Reference: in-order FIFO of expected words, credit count, and AR slot occupancy.
    bit          m_arv, m_buf_v, m_err;
    logic [31:0] m_araddr;
    int          m_outst;
    logic [31:0] slave_q[$];
    logic [31:0] exp_q[$];

    task automatic rand_cycle(input bit allow_req);
        bit          rel, exp_aok;
        bit          hs;
        logic [31:0] hs_addr, exp_d;
        set_idle();
        inst_sram_req  = allow_req && ($urandom_range(0, 99) < 60);
        inst_sram_wr   = inst_sram_req && ($urandom_range(0, 99) < 5);
        inst_sram_addr = $urandom & 32'hffff_fffc;
        arready        = ($urandom_range(0, 99) < 60);
        rresp          = 2'($urandom);
        rlast          = 1'($urandom);
        rdata          = $urandom;
        if (slave_q.size() > 0 && $urandom_range(0, 99) < 50) begin
            rvalid = 1'b1; rlast = 1'b1; rdata = fdat(slave_q[0]);
        end
        @(negedge clk);
        rel     = (RLAT != 0) ? m_buf_v : (rvalid && rlast);
        exp_aok = inst_sram_req && !inst_sram_wr && (!m_arv || arready) && (m_outst < MAXO || rel);
        checks++;
        if ({inst_sram_addr_ok, inst_sram_data_ok, arvalid, rready, wr_req_err}
            !== {exp_aok, rel, m_arv, 1'b1, m_err}) begin
            errors++;
            $display("FAIL rand_ctrl got aok/dok/arv/rready/err=%b%b%b%b%b exp %b%b%b1%b",
                     inst_sram_addr_ok, inst_sram_data_ok, arvalid, rready, wr_req_err,
                     exp_aok, rel, m_arv, m_err);
        end
        if (m_arv) begin
            checks++;
            if (araddr !== m_araddr) begin
                errors++; $display("FAIL rand_araddr got %h exp %h", araddr, m_araddr);
            end
        end
        if (rel) begin
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            checks++;
            if (inst_sram_rdata !== exp_d) begin
                errors++; $display("FAIL rand_rdata got %h exp %h", inst_sram_rdata, exp_d);
            end
        end
        hs      = arvalid && arready;
        hs_addr = araddr;
        @(posedge clk);
        if (rvalid) void'(slave_q.pop_front());
        if (hs) slave_q.push_back(hs_addr);
        if (exp_aok) begin
            m_arv = 1'b1; m_araddr = inst_sram_addr; exp_q.push_back(fdat(inst_sram_addr));
        end else if (arready) begin
            m_arv = 1'b0;
        end
        m_outst = m_outst + int'(exp_aok) - int'(rel);
        if (inst_sram_req && inst_sram_wr) m_err = 1'b1;
        m_buf_v = rvalid && rlast;
        #1;
    endtask

    task automatic test_random();
        int guard = 0;
        do_reset();
        m_arv = 0; m_buf_v = 0; m_err = 0; m_outst = 0; m_araddr = '0;
        slave_q.delete(); exp_q.delete();
        for (int i = 0; i < 500; i++) rand_cycle(1'b1);
        while ((m_outst != 0 || m_arv) && guard < 200) begin
            rand_cycle(1'b0);
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            errors++; $display("FAIL rand_drain_timeout outstanding=%0d exp 0", m_outst);
        end
    endtask

    initial begin
        set_idle();
        resetn = 1'b0;
        test_reset();
        test_single_fetch();
        test_ar_backpressure();
        test_credit_limit();
        test_write_req();
        test_order();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
